stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: synchronizes and debounces two active-low keys, runs the
// IDLE/RUN/LAP/PAUSE state machine and divides clk down to a 10 ms count tick.
module stopwatch_ctrl #(
    parameter int unsigned DELAY_TIME = 5000000,
    parameter int unsigned TICK_DIV   = 500000
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_display_stop,
    output logic       count_en,
    output logic       count_clr,
    output logic       tick_10ms,
    output logic       disp_hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        LAP   = 2'b11,
        PAUSE = 2'b10
    } state_t;

    localparam int CW = (DELAY_TIME > 1) ? $clog2(DELAY_TIME) : 1;
    localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_TIME - 1);
    localparam logic [31:0]   DIV_LAST = 32'(TICK_DIV - 1);

    // Bit 0 carries the start/pause key, bit 1 the lap/clear key.
    logic [1:0]    rawKey;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    deb_q;
    logic [1:0]    deb_d;
    logic [CW-1:0] stab_q [2];
    logic [CW-1:0] stab_d [2];
    logic [1:0]    pressEvt_q;
    logic [1:0]    pressEvt_d;

    state_t        state_q;
    state_t        state_d;
    logic          countEn_q;
    logic          dispHold_q;
    logic          countClr_q;
    logic          clr_d;
    logic [31:0]   div_q;
    logic [31:0]   div_d;
    logic          startEvt;
    logic          dispEvt;

    assign rawKey = {key_display_stop, key_start_pause};

    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < 2; k++) begin
            stab_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (stab_q[k] == DLY_LAST) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    stab_d[k] = stab_q[k] + 1'b1;
                end
            end
        end
        pressEvt_d = deb_q & ~deb_d;
    end

    always_ff @(posedge clk) begin
        if (!key_reset) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            stab_q[0]  <= '0;
            stab_q[1]  <= '0;
            pressEvt_q <= 2'b00;
        end else begin
            sync1_q    <= rawKey;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            stab_q[0]  <= stab_d[0];
            stab_q[1]  <= stab_d[1];
            pressEvt_q <= pressEvt_d;
        end
    end

    assign startEvt = pressEvt_q[0];
    assign dispEvt  = pressEvt_q[1];

    // Start is tested first in every state so it wins a same-cycle collision.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (startEvt) state_d = RUN;
            end
            RUN: begin
                if (startEvt)     state_d = PAUSE;
                else if (dispEvt) state_d = LAP;
            end
            LAP: begin
                if (startEvt)     state_d = PAUSE;
                else if (dispEvt) state_d = RUN;
            end
            PAUSE: begin
                if (startEvt) begin
                    state_d = RUN;
                end else if (dispEvt) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!key_reset) begin
            state_q    <= IDLE;
            countEn_q  <= 1'b0;
            dispHold_q <= 1'b0;
            countClr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            countEn_q  <= (state_d == RUN) || (state_d == LAP);
            dispHold_q <= (state_d == LAP);
            countClr_q <= clr_d;
        end
    end

    always_comb begin
        div_d = div_q;
        if (clr_d) begin
            div_d = '0;
        end else if (countEn_q) begin
            div_d = (div_q == DIV_LAST) ? 32'd0 : div_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!key_reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_10ms = countEn_q & (div_q == DIV_LAST) & ~countClr_q & key_reset;
    assign count_en  = countEn_q;
    assign count_clr = countClr_q;
    assign disp_hold = dispHold_q;
    assign state     = state_q;

endmodule
